// File: rtl/awmf_chain_seq.sv
// awmf_chain_seq: command sequencer for the AWMF-0165 beamformer daisy chain.
// Pops FWFT commands, drives the serializer, returns readback, flags timeouts.
module awmf_chain_seq #(
  parameter int CHIPS       = 4,
  parameter int CHIP_BITS   = 60,
  parameter int TIMEOUT_CYC = 4096,
  parameter int PULSE_LEN   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         trig_i,
  input  logic                         trig_mode_i,
  input  logic                         cmd_empty_i,
  input  logic [CHIPS*64-1:0]          cmd_data_i,
  input  logic                         cmd_write_i,
  output logic                         cmd_rd_o,
  output logic                         chain_start_o,
  output logic                         chain_write_o,
  output logic [CHIPS*CHIP_BITS-1:0]   chain_data_o,
  input  logic                         chain_busy_i,
  input  logic [CHIPS*CHIP_BITS-1:0]   chain_data_i,
  input  logic                         rsp_full_i,
  output logic                         rsp_wr_o,
  output logic [CHIPS*64-1:0]          rsp_data_o,
  output logic                         busy_o,
  output logic                         wr_done_o,
  output logic                         rd_done_o,
  output logic                         err_o,
  output logic [15:0]                  err_cnt_o
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int PW = $clog2(PULSE_LEN + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_HI,
    WAIT_LO,
    RSP,
    DONE
  } state_t;

  state_t          state;
  logic            trig_s1;
  logic            trig_s2;
  logic            trig_s3;
  logic            trig_pend;
  logic            trig_rise;
  logic [TW-1:0]   tmo;
  logic            tmo_hit;
  logic            wait_stuck;
  logic            launch;
  logic            wr_go;
  logic            rd_go;
  logic            err_go;
  logic [PW-1:0]   wr_pc;
  logic [PW-1:0]   rd_pc;
  logic [PW-1:0]   err_pc;
  logic            pad_unused;

  // Pad bits above CHIP_BITS in each command slot carry no payload.
  assign pad_unused = ^cmd_data_i;

  assign trig_rise  = trig_s2 & ~trig_s3;
  assign tmo_hit    = (tmo == TW'(TIMEOUT_CYC - 1));
  assign wait_stuck = ((state == WAIT_HI) && !chain_busy_i) ||
                      ((state == WAIT_LO) &&  chain_busy_i);
  assign err_go     = wait_stuck && tmo_hit;
  assign launch     = (state == IDLE) && !cmd_empty_i &&
                      (!trig_mode_i || trig_pend);
  assign wr_go      = (state == DONE) &&  chain_write_o;
  assign rd_go      = (state == DONE) && !chain_write_o;
  assign busy_o     = (state != IDLE);

  // Synchronise trigger, detect rising edge, latch one pending launch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_s3   <= 1'b0;
      trig_pend <= 1'b0;
    end else begin
      trig_s1 <= trig_i;
      trig_s2 <= trig_s1;
      trig_s3 <= trig_s2;
      if (!trig_mode_i)
        trig_pend <= 1'b0;
      else if (trig_rise)
        trig_pend <= 1'b1;
      else if (state == LOAD)
        trig_pend <= 1'b0;
    end
  end

  // Main sequencer with registered strobes, data and error count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cmd_rd_o      <= 1'b0;
      chain_start_o <= 1'b0;
      chain_write_o <= 1'b0;
      chain_data_o  <= '0;
      rsp_wr_o      <= 1'b0;
      rsp_data_o    <= '0;
      tmo           <= '0;
      err_cnt_o     <= '0;
    end else begin
      cmd_rd_o      <= 1'b0;
      chain_start_o <= 1'b0;
      rsp_wr_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            state         <= LOAD;
            cmd_rd_o      <= 1'b1;
            chain_start_o <= 1'b1;
            chain_write_o <= cmd_write_i;
            for (int k = 0; k < CHIPS; k++)
              chain_data_o[k*CHIP_BITS +: CHIP_BITS] <=
                cmd_data_i[k*64 +: CHIP_BITS];
          end
        end
        LOAD: begin
          state <= WAIT_HI;
          tmo   <= '0;
        end
        WAIT_HI: begin
          if (chain_busy_i) begin
            state <= WAIT_LO;
            tmo   <= '0;
          end else if (tmo_hit) begin
            state <= IDLE;
            if (err_cnt_o != 16'hFFFF)
              err_cnt_o <= err_cnt_o + 16'd1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!chain_busy_i) begin
            if (chain_write_o) begin
              state <= DONE;
            end else begin
              state <= RSP;
              // Readback lands in reverse chain order.
              for (int k = 0; k < CHIPS; k++)
                rsp_data_o[k*64 +: 64] <= 64'(
                  chain_data_i[(CHIPS-1-k)*CHIP_BITS +: CHIP_BITS]);
            end
          end else if (tmo_hit) begin
            state <= IDLE;
            if (err_cnt_o != 16'hFFFF)
              err_cnt_o <= err_cnt_o + 16'd1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RSP: begin
          if (!rsp_full_i) begin
            rsp_wr_o <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-complete pulse; a new start reloads the full length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_done_o <= 1'b0;
      wr_pc     <= '0;
    end else if (wr_go) begin
      wr_done_o <= 1'b1;
      wr_pc     <= PW'(PULSE_LEN - 1);
    end else if (wr_pc != '0) begin
      wr_pc <= wr_pc - 1'b1;
    end else begin
      wr_done_o <= 1'b0;
    end
  end

  // Read-complete pulse; a new start reloads the full length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_done_o <= 1'b0;
      rd_pc     <= '0;
    end else if (rd_go) begin
      rd_done_o <= 1'b1;
      rd_pc     <= PW'(PULSE_LEN - 1);
    end else if (rd_pc != '0) begin
      rd_pc <= rd_pc - 1'b1;
    end else begin
      rd_done_o <= 1'b0;
    end
  end

  // Timeout pulse; a new abort reloads the full length.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o  <= 1'b0;
      err_pc <= '0;
    end else if (err_go) begin
      err_o  <= 1'b1;
      err_pc <= PW'(PULSE_LEN - 1);
    end else if (err_pc != '0) begin
      err_pc <= err_pc - 1'b1;
    end else begin
      err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_awmf_chain_seq.sv
// tb_awmf_chain_seq: vector table plus directed sequences for awmf_chain_seq.
// Models the command FIFO and serializer; expected results via scoreboard queues.
module tb_awmf_chain_seq;

  localparam int CHIPS = 4;
  localparam int CB    = 60;
  localparam int TMO   = 64;
  localparam int PL    = 32;
  localparam int DW    = CHIPS * 64;
  localparam int TXW   = CHIPS * CB;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            trig_i = 1'b0;
  logic            trig_mode_i = 1'b0;
  logic            cmd_empty_i;
  logic [DW-1:0]   cmd_data_i;
  logic            cmd_write_i;
  logic            cmd_rd_o;
  logic            chain_start_o;
  logic            chain_write_o;
  logic [TXW-1:0]  chain_data_o;
  logic            chain_busy_i = 1'b0;
  logic [TXW-1:0]  chain_data_i = '0;
  logic            rsp_full_i = 1'b0;
  logic            rsp_wr_o;
  logic [DW-1:0]   rsp_data_o;
  logic            busy_o;
  logic            wr_done_o;
  logic            rd_done_o;
  logic            err_o;
  logic [15:0]     err_cnt_o;

  always #5 clk_i = ~clk_i;

  awmf_chain_seq #(
    .CHIPS(CHIPS), .CHIP_BITS(CB), .TIMEOUT_CYC(TMO), .PULSE_LEN(PL)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .trig_i(trig_i),
    .trig_mode_i(trig_mode_i), .cmd_empty_i(cmd_empty_i),
    .cmd_data_i(cmd_data_i), .cmd_write_i(cmd_write_i),
    .cmd_rd_o(cmd_rd_o), .chain_start_o(chain_start_o),
    .chain_write_o(chain_write_o), .chain_data_o(chain_data_o),
    .chain_busy_i(chain_busy_i), .chain_data_i(chain_data_i),
    .rsp_full_i(rsp_full_i), .rsp_wr_o(rsp_wr_o),
    .rsp_data_o(rsp_data_o), .busy_o(busy_o),
    .wr_done_o(wr_done_o), .rd_done_o(rd_done_o),
    .err_o(err_o), .err_cnt_o(err_cnt_o)
  );

  // FWFT command FIFO model: stimulus writes, monitor pops.
  logic [DW-1:0] fq_d [16];
  logic          fq_w [16];
  int            wp = 0;
  int            rp = 0;

  assign cmd_empty_i = (wp == rp);
  assign cmd_data_i  = fq_d[rp % 16];
  assign cmd_write_i = fq_w[rp % 16];

  // Serializer controls set by stimulus.
  int             ser_len = 10;
  bit             ser_stuck = 1'b0;
  logic [TXW-1:0] ser_rx = '0;
  int             ser_cnt = 0;

  // Monitor observations.
  int             n_start = 0;
  int             n_pop = 0;
  int             n_rsp = 0;
  int             wr_hi = 0;
  int             rd_hi = 0;
  int             err_hi = 0;
  logic [TXW-1:0] cap_tx = '0;
  logic           cap_wr = 1'b0;
  logic [DW-1:0]  cap_rsp = '0;

  always @(negedge clk_i) begin
    if (cmd_rd_o) begin
      rp = rp + 1;
      n_pop = n_pop + 1;
    end
    if (chain_start_o) begin
      n_start = n_start + 1;
      cap_tx = chain_data_o;
      cap_wr = chain_write_o;
      chain_data_i = ser_rx;
      if (!ser_stuck)
        ser_cnt = ser_len;
    end
    chain_busy_i = (ser_cnt > 0);
    if (ser_cnt > 0)
      ser_cnt = ser_cnt - 1;
    if (rsp_wr_o) begin
      n_rsp = n_rsp + 1;
      cap_rsp = rsp_data_o;
    end
    if (wr_done_o) wr_hi = wr_hi + 1;
    if (rd_done_o) rd_hi = rd_hi + 1;
    if (err_o) err_hi = err_hi + 1;
  end

  typedef struct {
    logic [DW-1:0]  cmd;
    logic           wr;
    logic [TXW-1:0] rx;
    logic [TXW-1:0] exp_tx;
    logic [DW-1:0]  exp_rsp;
  } vec_t;

  typedef struct {
    logic           wr;
    logic [TXW-1:0] tx;
  } etx_t;

  vec_t          vt [4];
  etx_t          tx_q [$];
  logic [DW-1:0] rsp_q [$];
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic push_cmd(input logic [DW-1:0] d, input logic w);
    fq_d[wp % 16] = d;
    fq_w[wp % 16] = w;
    wp = wp + 1;
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (!chain_start_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    chk("start_seen", chain_start_o, 1);
  endtask

  task automatic wait_done(input int s0);
    int k;
    k = 0;
    while (!(n_start > s0 && !busy_o) && k < 300) begin
      @(negedge clk_i);
      k++;
    end
    chk("done_in_time", k < 300, 1);
  endtask

  task automatic pulse_trig(input int hi);
    trig_i = 1'b1;
    repeat (hi) @(negedge clk_i);
    trig_i = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int   s_st, s_pp, s_rs, s_wr, s_rd;
    etx_t e;
    s_st = n_start; s_pp = n_pop; s_rs = n_rsp;
    s_wr = wr_hi;   s_rd = rd_hi;
    ser_rx = vt[i].rx;
    tx_q.push_back('{vt[i].wr, vt[i].exp_tx});
    if (!vt[i].wr) rsp_q.push_back(vt[i].exp_rsp);
    push_cmd(vt[i].cmd, vt[i].wr);
    if (i == 0) begin
      chk("no_start_same_cyc", chain_start_o, 0);
      @(negedge clk_i);
      chk("launch_lat_start", chain_start_o, 1);
      chk("launch_lat_pop", cmd_rd_o, 1);
    end
    wait_done(s_st);
    repeat (40) @(negedge clk_i);
    e = tx_q.pop_front();
    chk($sformatf("v%0d_starts", i), n_start - s_st, 1);
    chk($sformatf("v%0d_pops", i), n_pop - s_pp, 1);
    chk($sformatf("v%0d_tx", i), cap_tx, e.tx);
    chk($sformatf("v%0d_dir", i), cap_wr, e.wr);
    chk($sformatf("v%0d_rsp_n", i), n_rsp - s_rs, e.wr ? 0 : 1);
    if (!e.wr)
      chk($sformatf("v%0d_rsp", i), cap_rsp, rsp_q.pop_front());
    chk($sformatf("v%0d_wr_len", i), wr_hi - s_wr, e.wr ? PL : 0);
    chk($sformatf("v%0d_rd_len", i), rd_hi - s_rd, e.wr ? 0 : PL);
  endtask

  initial begin
    int s_st, s_pp, s_rs, s_wr, s_rd, s_er, k;

    vt[0].cmd = {64'hA5A0_0000_0000_0003, 64'hA5A0_0000_0000_0002,
                 64'hA5A0_0000_0000_0001, 64'hA5A0_0000_0000_0000};
    vt[0].wr = 1'b1;
    vt[0].rx = '0;
    vt[0].exp_tx = {60'h5A0_0000_0000_0003, 60'h5A0_0000_0000_0002,
                    60'h5A0_0000_0000_0001, 60'h5A0_0000_0000_0000};
    vt[0].exp_rsp = '0;

    vt[1].cmd = {64'hFFFF_0000_1234_0003, 64'hFFFF_0000_1234_0002,
                 64'hFFFF_0000_1234_0001, 64'hFFFF_0000_1234_0000};
    vt[1].wr = 1'b0;
    vt[1].rx = {60'h3, 60'h2, 60'h1, 60'h0};
    vt[1].exp_tx = {60'hFFF_0000_1234_0003, 60'hFFF_0000_1234_0002,
                    60'hFFF_0000_1234_0001, 60'hFFF_0000_1234_0000};
    vt[1].exp_rsp = {64'h0, 64'h1, 64'h2, 64'h3};

    vt[2].cmd = {64'h0, 64'h0, 64'h0, 64'hDEAD_BEEF_CAFE_F00D};
    vt[2].wr = 1'b0;
    vt[2].rx = {60'h800_0000_0000_0001, 60'h0,
                60'h123_4567_89AB_CDEF, 60'hFFF_FFFF_FFFF_FFFF};
    vt[2].exp_tx = {60'h0, 60'h0, 60'h0, 60'hEAD_BEEF_CAFE_F00D};
    vt[2].exp_rsp = {64'h0FFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF,
                     64'h0, 64'h0800_0000_0000_0001};

    vt[3].cmd = '1;
    vt[3].wr = 1'b1;
    vt[3].rx = '0;
    vt[3].exp_tx = '1;
    vt[3].exp_rsp = '0;

    // Reset state.
    repeat (3) @(negedge clk_i);
    chk("reset_outs",
        {cmd_rd_o, chain_start_o, chain_write_o, rsp_wr_o, busy_o,
         wr_done_o, rd_done_o, err_o, err_cnt_o,
         |chain_data_o, |rsp_data_o}, 0);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // Immediate-mode vector table.
    for (int i = 0; i < 4; i++)
      run_vec(i);

    // Triggered mode: launches only on serviced edges.
    trig_mode_i = 1'b1;
    ser_len = 10;
    s_st = n_start;
    for (int i = 0; i < 4; i++)
      push_cmd({4{64'(i + 16)}}, 1'b1);
    repeat (50) @(negedge clk_i);
    chk("trig_no_edge", n_start - s_st, 0);
    pulse_trig(3);
    repeat (200) @(negedge clk_i);
    chk("trig_edge_a", n_start - s_st, 1);
    pulse_trig(3);
    k = 0;
    while (n_start - s_st < 2 && k < 50) begin
      @(negedge clk_i);
      k++;
    end
    chk("trig_edge_b", n_start - s_st, 2);
    repeat (1) @(negedge clk_i);
    pulse_trig(2);
    repeat (2) @(negedge clk_i);
    pulse_trig(2);
    repeat (200) @(negedge clk_i);
    chk("trig_double_one", n_start - s_st, 3);
    chk("trig_left_queued", wp - rp, 1);
    pulse_trig(3);
    repeat (200) @(negedge clk_i);
    chk("trig_edge_e", n_start - s_st, 4);
    chk("trig_fifo_empty", wp - rp, 0);
    trig_mode_i = 1'b0;
    repeat (5) @(negedge clk_i);

    // Timeout with busy stuck low, then a clean command.
    ser_stuck = 1'b1;
    s_st = n_start; s_pp = n_pop; s_rs = n_rsp;
    s_wr = wr_hi;   s_er = err_hi;
    push_cmd({4{64'h0BAD}}, 1'b1);
    wait_start();
    k = 0;
    while (busy_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    chk("tmo_cycles", k, TMO + 1);
    chk("tmo_err_rise", err_o, 1);
    repeat (40) @(negedge clk_i);
    chk("tmo_err_len", err_hi - s_er, PL);
    chk("tmo_err_cnt", err_cnt_o, 1);
    chk("tmo_popped", n_pop - s_pp, 1);
    chk("tmo_no_done", wr_hi - s_wr, 0);
    chk("tmo_no_rsp", n_rsp - s_rs, 0);
    ser_stuck = 1'b0;
    push_cmd({4{64'h0600D}}, 1'b1);
    wait_done(s_st + 1);
    repeat (40) @(negedge clk_i);
    chk("tmo_next_start", n_start - s_st, 2);
    chk("tmo_next_done", wr_hi - s_wr, PL);

    // Response back-pressure.
    rsp_full_i = 1'b1;
    s_rs = n_rsp; s_rd = rd_hi; s_st = n_start;
    ser_rx = vt[1].rx;
    rsp_q.push_back(vt[1].exp_rsp);
    push_cmd(vt[1].cmd, 1'b0);
    wait_start();
    repeat (50) @(negedge clk_i);
    chk("bp_no_push", n_rsp - s_rs, 0);
    chk("bp_busy", busy_o, 1);
    chk("bp_data_a", rsp_data_o, rsp_q[0]);
    repeat (5) @(negedge clk_i);
    chk("bp_data_b", rsp_data_o, rsp_q[0]);
    rsp_full_i = 1'b0;
    @(negedge clk_i);
    chk("bp_push_lat", rsp_wr_o, 1);
    chk("bp_push_data", rsp_data_o, rsp_q.pop_front());
    wait_done(s_st);
    repeat (40) @(negedge clk_i);
    chk("bp_one_push", n_rsp - s_rs, 1);
    chk("bp_rd_len", rd_hi - s_rd, PL);

    // Reset in WAIT_LO aborts silently.
    ser_len = 30;
    s_pp = n_pop; s_rs = n_rsp; s_wr = wr_hi;
    s_rd = rd_hi; s_er = err_hi;
    push_cmd(vt[2].cmd, 1'b0);
    wait_start();
    repeat (10) @(negedge clk_i);
    chk("rst_pre_busy", busy_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_outs",
        {cmd_rd_o, chain_start_o, chain_write_o, rsp_wr_o, busy_o,
         wr_done_o, rd_done_o, err_o, err_cnt_o,
         |chain_data_o, |rsp_data_o}, 0);
    rst_i = 1'b0;
    repeat (60) @(negedge clk_i);
    chk("rst_one_pop", n_pop - s_pp, 1);
    chk("rst_no_rsp", n_rsp - s_rs, 0);
    chk("rst_no_pulse", (wr_hi - s_wr) + (rd_hi - s_rd) + (err_hi - s_er), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/awmf_chain_seq.md
Name: awmf_chain_seq

Overview:
Parametrised successor controller for the AWMF-0165 beamformer daisy chain, generalised to CHIPS devices of CHIP_BITS each.
- Pops packed commands from a first-word-fall-through command FIFO and drives the chain serializer.
- For read commands, returns readback to a response FIFO.
- Adds per-command direction, immediate/triggered launch mode, chain-busy timeout with error flag, response back-pressure and parametrised completion pulses.
- Sits between the PS register/FIFO bridge and the chain serializer.

Parameters:
CHIPS, 4, devices in chain (1..8)
CHIP_BITS, 60, serial word per device (<=63)
TIMEOUT_CYC, 4096, max cycles in any chain-wait state before abort (>=2)
PULSE_LEN, 32, width in clk_i cycles of done/error pulses (>=1)

Ports:
clk_i  in  1  sole clock, all logic posedge
rst_i  in  1  synchronous active-high reset
trig_i  in  1  async launch trigger (CPI edge); rising edge used
trig_mode_i  in  1  0=launch on FIFO non-empty, 1=launch on trigger edge
cmd_empty_i  in  1  command FIFO empty (FWFT)
cmd_data_i  in  CHIPS*64  command word; slot k = bits [k*64 +: 64]
cmd_write_i  in  1  direction of head command: 1=write, 0=read
cmd_rd_o  out  1  FIFO pop, one-cycle pulse
chain_start_o  out  1  serializer start, one-cycle pulse
chain_write_o  out  1  direction to serializer, held with data
chain_data_o  out  CHIPS*CHIP_BITS  packed TX data
chain_busy_i  in  1  serializer busy
chain_data_i  in  CHIPS*CHIP_BITS  RX data, valid when busy falls
rsp_full_i  in  1  response FIFO full
rsp_wr_o  out  1  response push, one-cycle pulse
rsp_data_o  out  CHIPS*64  response word
busy_o  out  1  high whenever state != IDLE
wr_done_o  out  1  write-complete pulse, PULSE_LEN cycles
rd_done_o  out  1  read-complete pulse, PULSE_LEN cycles
err_o  out  1  timeout pulse, PULSE_LEN cycles
err_cnt_o  out  16  saturating timeout count

Behaviour:
- Reset: every output 0, state IDLE, trigger sync/pending cleared, err_cnt_o=0. Reset mid-transaction aborts with no pop, push or pulse.
- Trigger: two-flop synchroniser plus edge detect; a rising edge sets trig_pend in any state.
- trig_pend is cleared on LOAD and when trig_mode_i=0. Multiple edges before LOAD collapse to one.
- FSM states: IDLE, LOAD, WAIT_HI, WAIT_LO, RSP, DONE.
- IDLE -> LOAD when cmd_empty_i=0 and (trig_mode_i=0 or trig_pend=1).
- LOAD (1 cycle):
  - capture cmd_data_i and cmd_write_i;
  - assert cmd_rd_o and chain_start_o;
  - chain_data_o[k*CHIP_BITS +: CHIP_BITS] = cmd_data_i[k*64 +: CHIP_BITS];
  - upper pad bits of each slot are ignored;
  - chain_data_o/chain_write_o hold until the next LOAD.
- Latency: launch condition at cycle n -> cmd_rd_o and chain_start_o high at n+1.
- WAIT_HI: wait for chain_busy_i=1, then -> WAIT_LO.
- WAIT_LO: wait for chain_busy_i=0.
  - Write command -> DONE.
  - Read command -> RSP.
- Timeout counter:
  - reset on entering WAIT_HI and on entering WAIT_LO;
  - reaching TIMEOUT_CYC-1 -> IDLE, err_o pulse, err_cnt_o+1 (saturates at 0xFFFF);
  - no response push, no done pulse; the command is already popped and is not retried.
- RSP:
  - hold while rsp_full_i=1 (no timeout applies);
  - when rsp_full_i=0: one-cycle rsp_wr_o, then -> DONE;
  - rsp_data_o slot k = {pad zeros, chain_data_i chip (CHIPS-1-k)}, i.e. chain order reversed;
  - readback is captured on the busy-falling cycle and held stable while waiting.
- DONE (1 cycle): start wr_done_o or rd_done_o per captured direction, then -> IDLE.
  - Back-to-back commands have minimum 2 IDLE-free cycles between starts: DONE then IDLE sees FIFO.
- Pulses: each output has an independent counter.
  - A new start while the pulse is active restarts the full PULSE_LEN.
  - Pulse begins the cycle after DONE or timeout.
- chain_busy_i already high at LOAD: WAIT_HI exits on the next cycle (legal).
- trig_mode_i change is honoured only in IDLE; in-flight commands complete unaffected.

Test Plan:
- Immediate write, CHIPS=4: one cmd, slot k = 64'hA5A0_0000_0000_000k, busy high 10 cycles -> single start one cycle after non-empty; chain_data_o slot k low 60 bits match; wr_done_o high exactly 32 cycles; no rsp_wr_o.
- Read reversal: chain_data_i chip j = 60'h0000_0000_0000_00j -> rsp_data_o slot k = 64'h(3-k); rd_done_o 32 cycles; exactly one rsp_wr_o.
- Triggered mode: 3 cmds queued, trig_i edges 200 cycles apart, plus a double edge within one transaction -> exactly one launch per serviced trigger; no launch without an edge; the double edge yields one extra launch only.
- Timeout: TIMEOUT_CYC=64, chain_busy_i stuck 0 after start -> abort at 64 cycles into WAIT_HI; err_o pulse; err_cnt_o=1; cmd popped; next cmd launches normally.
- Back-pressure: read completes with rsp_full_i=1 for 50 cycles -> rsp_wr_o waits; rsp_data_o stable; busy_o high; push one cycle after full drops.
- Reset mid-WAIT_LO -> all outputs 0 next cycle; no done/err pulse; FIFO not popped again.
